// File: rtl/jetson_spi_master_pkg.sv
// Shared definitions for the Jetson-side SPI frame master.
//   Command frame  : {addr[3:0], ctrl[3:0], data[23:0]}, bit 31 first on MOSI.
//   Response frame : {addr[3:0], data[27:0]}, bit 31 first on MISO.
// Holds the frame layout constants, the master FSM state encoding and the
// no-op frame used for read-only polls.
package jetson_spi_master_pkg;

  localparam int FRAME_W  = 32;
  localparam int ADDR_MSB = 31;
  localparam int CTRL_MSB = 27;
  localparam int DATA_W   = 24;
  localparam int RDATA_W  = 28;

  // Address 0 is a no-op at the slave, so an all-zero frame only clocks
  // the response out.
  localparam logic [FRAME_W-1:0] NOP_FRAME = 32'h0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

endpackage

// File: rtl/jetson_spi_master_spi_clk_divider.sv
// SPI clock generator for the frame master.
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   en_i            run the divider (high only while shifting); when low the
//                   counter is cleared and spi_clk is held low (mode 0 idle)
//   rise_tick_o     one-cycle strobe on the clk cycle where spi_clk goes high
//   fall_tick_o     one-cycle strobe on the clk cycle where spi_clk goes low
//   spi_clk_o       registered SPI clock level
// Each half-period lasts HALF_DIV clk cycles; the first half after enable is
// the low half.
module jetson_spi_master_spi_clk_divider #(
  parameter int HALF_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic rise_tick_o,
  output logic fall_tick_o,
  output logic spi_clk_o
);

  localparam int CW = $clog2(HALF_DIV) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          lvl_q;
  logic          edge_w;

  // The counter reloads on every edge, so it never needs to wrap.
  assign edge_w      = en_i && (cnt_q == HALF_LAST);
  assign rise_tick_o = edge_w && !lvl_q;
  assign fall_tick_o = edge_w && lvl_q;
  assign spi_clk_o   = lvl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      lvl_q <= 1'b0;
    end else if (!en_i) begin
      cnt_q <= '0;
      lvl_q <= 1'b0;
    end else if (edge_w) begin
      cnt_q <= '0;
      lvl_q <= ~lvl_q;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/jetson_spi_master.sv
// SPI initiator for the Jetson frame protocol (opposite end of the SPI slave
// bridge). Shifts a 32-bit command out on MOSI while capturing a 32-bit
// response from MISO, paced by the slave's not_empty / not_full flags.
// Ports:
//   clk, rst_n                 system clock, asynchronous active-low reset
//   tx_valid_i/tx_ready_o      command handshake, tx_data_i sampled on accept
//   tx_data_i[31:0]            command frame, bit 31 first
//   rx_valid_o                 one-cycle pulse, rx_data_o holds a real response
//   rx_data_o[31:0]            last captured response frame
//   busy_o                     frame in progress (anything but IDLE)
//   spi_clk_o/spi_mosi_o/spi_cs_o   SPI mode 0 outputs, CS active low
//   spi_miso_i                 slave data (asynchronous, synchronised here)
//   slv_not_empty_i/slv_not_full_i  slave flags (asynchronous, synchronised)
//   dbg_state_o                current FSM state
// Build option: JETSON_SPI_MASTER_LOOPBACK_EN -- when defined, the shift
// register captures the master's own MOSI instead of MISO and rx_valid
// pulses on every frame (on-board self-test).
//
// Handshake: a command transfers on a rising clk edge where tx_valid_i and
// tx_ready_o are both high. tx_ready_o depends only on registered state and
// the synchronised not_full flag, never on tx_valid_i, and is only high in
// IDLE. rx_valid_o is a one-cycle pulse with no back-pressure.
module jetson_spi_master
  import jetson_spi_master_pkg::*;
#(
  parameter int HALF_DIV   = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tx_valid_i,
  output logic               tx_ready_o,
  input  logic [FRAME_W-1:0] tx_data_i,
  output logic               rx_valid_o,
  output logic [FRAME_W-1:0] rx_data_o,
  output logic               busy_o,
  output logic               spi_clk_o,
  output logic               spi_mosi_o,
  input  logic               spi_miso_i,
  output logic               spi_cs_o,
  input  logic               slv_not_empty_i,
  input  logic               slv_not_full_i,
  output state_e             dbg_state_o
);

  localparam int CNT_MAX = (HALF_DIV > GAP_CYCLES) ? HALF_DIV : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

  // Two-flop synchronisers for everything coming from the slave.
  logic [1:0] miso_sync_q;
  logic [1:0] ne_sync_q;
  logic [1:0] nf_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_sync_q <= '0;
      ne_sync_q   <= '0;
      nf_sync_q   <= '0;
    end else begin
      miso_sync_q <= {miso_sync_q[0], spi_miso_i};
      ne_sync_q   <= {ne_sync_q[0], slv_not_empty_i};
      nf_sync_q   <= {nf_sync_q[0], slv_not_full_i};
    end
  end

  state_e             state_q;
  logic [CW-1:0]      cyc_q;
  logic [4:0]         bit_cnt_q;
  logic [FRAME_W-1:0] sr_q;
  logic               rd_flag_q;
  logic               spi_cs_q;
  logic               spi_mosi_q;
  logic               rx_valid_q;
  logic [FRAME_W-1:0] rx_data_q;

  logic rise_tick;
  logic fall_tick;
  logic shift_in;

`ifdef JETSON_SPI_MASTER_LOOPBACK_EN
  // spi_mosi_q holds the bit currently on the wire at every rising edge,
  // so each frame captures its own command.
  assign shift_in = spi_mosi_q;
  localparam bit RX_EVERY_FRAME = 1'b1;
`else
  assign shift_in = miso_sync_q[1];
  localparam bit RX_EVERY_FRAME = 1'b0;
`endif

  jetson_spi_master_spi_clk_divider #(
    .HALF_DIV (HALF_DIV)
  ) u_clk_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (state_q == ST_SHIFT),
    .rise_tick_o (rise_tick),
    .fall_tick_o (fall_tick),
    .spi_clk_o   (spi_clk_o)
  );

  assign tx_ready_o  = (state_q == ST_IDLE) && nf_sync_q[1];
  assign busy_o      = (state_q != ST_IDLE);
  assign spi_cs_o    = spi_cs_q;
  assign spi_mosi_o  = spi_mosi_q;
  assign rx_valid_o  = rx_valid_q;
  assign rx_data_o   = rx_data_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cyc_q      <= '0;
      bit_cnt_q  <= '0;
      sr_q       <= '0;
      rd_flag_q  <= 1'b0;
      spi_cs_q   <= 1'b1;
      spi_mosi_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          cyc_q     <= '0;
          bit_cnt_q <= '0;
          // A command always wins over a read-only poll; when both are
          // pending the command frame also carries the read.
          if (tx_valid_i && nf_sync_q[1]) begin
            sr_q       <= tx_data_i;
            rd_flag_q  <= ne_sync_q[1];
            spi_cs_q   <= 1'b0;
            spi_mosi_q <= tx_data_i[ADDR_MSB];
            state_q    <= ST_SETUP;
          end else if (ne_sync_q[1]) begin
            sr_q       <= NOP_FRAME;
            rd_flag_q  <= 1'b1;
            spi_cs_q   <= 1'b0;
            spi_mosi_q <= NOP_FRAME[ADDR_MSB];
            state_q    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cyc_q == HALF_LAST) begin
            cyc_q   <= '0;
            state_q <= ST_SHIFT;
          end else begin
            cyc_q <= cyc_q + CW'(1);
          end
        end
        ST_SHIFT: begin
          if (rise_tick) begin
            sr_q      <= {sr_q[FRAME_W-2:0], shift_in};
            bit_cnt_q <= bit_cnt_q + 5'd1;
          end
          // After the 32nd sample the 5-bit counter has wrapped to 0; the
          // falling edge that follows ends the shift with spi_clk low.
          if (fall_tick) begin
            if (bit_cnt_q == 5'd0) begin
              state_q <= ST_HOLD;
            end else begin
              spi_mosi_q <= sr_q[FRAME_W-1];
            end
          end
        end
        ST_HOLD: begin
          if (cyc_q == HALF_LAST) begin
            cyc_q      <= '0;
            spi_cs_q   <= 1'b1;
            spi_mosi_q <= 1'b0;
            rx_data_q  <= sr_q;
            rx_valid_q <= rd_flag_q | RX_EVERY_FRAME;
            state_q    <= ST_GAP;
          end else begin
            cyc_q <= cyc_q + CW'(1);
          end
        end
        ST_GAP: begin
          // Lets the slave see CS high and refresh its flags before the
          // next launch decision.
          if (cyc_q == GAP_LAST) begin
            cyc_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cyc_q <= cyc_q + CW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jetson_spi_master.sv
// Bench for jetson_spi_master: a behavioural SPI slave drives MISO and
// collects MOSI, and a scoreboard checks every frame and every rx_valid
// against expectations queued when stimulus is issued.
module tb_jetson_spi_master;
  import jetson_spi_master_pkg::*;

  localparam int HALF_DIV      = 4;
  localparam int GAP_CYCLES    = 8;
  localparam int CS_LOW_CYCLES = HALF_DIV + 32 * 2 * HALF_DIV + HALF_DIV;
`ifdef JETSON_SPI_MASTER_LOOPBACK_EN
  localparam bit LOOPBACK = 1'b1;
`else
  localparam bit LOOPBACK = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [31:0] tx_data  = '0;
  logic        rx_valid;
  logic [31:0] rx_data;
  logic        busy;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;
  logic        spi_cs;
  logic        not_empty = 1'b0;
  logic        not_full  = 1'b0;
  state_e      dbg_state;

  jetson_spi_master #(
    .HALF_DIV   (HALF_DIV),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .tx_valid_i      (tx_valid),
    .tx_ready_o      (tx_ready),
    .tx_data_i       (tx_data),
    .rx_valid_o      (rx_valid),
    .rx_data_o       (rx_data),
    .busy_o          (busy),
    .spi_clk_o       (spi_clk),
    .spi_mosi_o      (spi_mosi),
    .spi_miso_i      (spi_miso),
    .spi_cs_o        (spi_cs),
    .slv_not_empty_i (not_empty),
    .slv_not_full_i  (not_full),
    .dbg_state_o     (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_mosi_q[$];
  logic [31:0] exp_rx_q[$];

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name, input string what);
    checks++;
    failures++;
    $display("FAIL %s actual=%s expected=none", name, what);
  endtask

  // ---------------- behavioural SPI slave ----------------
  logic [31:0] slave_word = '0;
  logic [31:0] miso_sr    = '0;
  logic [31:0] mosi_cap   = '0;
  int nclk        = 0;
  int cs_low_cnt  = 0;
  int cs_high_cnt = 0;
  bit frame_active = 1'b0;
  bit abort_frame  = 1'b0;
  bit seen_frame   = 1'b0;

  always @(negedge spi_cs) begin
    frame_active = 1'b1;
    miso_sr      = slave_word;
    spi_miso     = miso_sr[31];
    mosi_cap     = '0;
    nclk         = 0;
    cs_low_cnt   = 0;
    if (seen_frame) begin
      checks++;
      if (cs_high_cnt < GAP_CYCLES) begin
        failures++;
        $display("FAIL cs_gap actual=%0d required>=%0d", cs_high_cnt, GAP_CYCLES);
      end
    end
  end

  always @(negedge spi_clk) begin
    if (frame_active) begin
      miso_sr  = miso_sr << 1;
      spi_miso = miso_sr[31];
    end
  end

  always @(posedge spi_clk) begin
    if (frame_active) begin
      mosi_cap = {mosi_cap[30:0], spi_mosi};
      nclk++;
    end
  end

  always @(posedge spi_cs) begin
    if (frame_active) begin
      frame_active = 1'b0;
      cs_high_cnt  = 0;
      if (abort_frame) begin
        seen_frame = 1'b0;
      end else begin
        seen_frame = 1'b1;
        if (exp_mosi_q.size() == 0) fail_evt("mosi_frame", "unexpected frame");
        else check_val("mosi_frame", mosi_cap, exp_mosi_q.pop_front());
        check_val("spi_clk_pulses", 32'(nclk), 32'd32);
        check_val("cs_low_cycles", 32'(cs_low_cnt), 32'(CS_LOW_CYCLES));
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (spi_cs === 1'b0) cs_low_cnt++;
    else cs_high_cnt++;
    if (rx_valid === 1'b1) begin
      if (exp_rx_q.size() == 0) fail_evt("rx_valid", "unexpected pulse");
      else check_val("rx_data", rx_data, exp_rx_q.pop_front());
    end
    if (tx_ready === 1'b1) begin
      checks++;
      if (busy !== 1'b0 || spi_cs !== 1'b1) begin
        failures++;
        $display("FAIL tx_ready_outside_idle actual=busy%b_cs%b expected=busy0_cs1", busy, spi_cs);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) fail_evt("idle_timeout", "still busy");
    @(negedge clk);
  endtask

  task automatic wait_cs_low();
    int n = 0;
    while (spi_cs !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (spi_cs !== 1'b0) fail_evt("cs_low_timeout", "cs stayed high");
  endtask

  // Offer a command; expectations are queued once ready is seen, then the
  // accept edge passes and tx_data is scrambled to prove it is not re-read.
  task automatic issue(input logic [31:0] d, input bit rd, input logic [31:0] resp, input bit track);
    int n = 0;
    tx_valid = 1'b1;
    tx_data  = d;
    while (tx_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (tx_ready !== 1'b1) begin
      fail_evt("tx_accept_timeout", "no tx_ready");
    end else if (track) begin
      exp_mosi_q.push_back(d);
      if (LOOPBACK) exp_rx_q.push_back(d);
      else if (rd) exp_rx_q.push_back(resp);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = $urandom();
  endtask

  task automatic poll(input logic [31:0] resp);
    slave_word = resp;
    exp_mosi_q.push_back(NOP_FRAME);
    exp_rx_q.push_back(LOOPBACK ? NOP_FRAME : resp);
    not_empty = 1'b1;
    wait_cs_low();
    not_empty = 1'b0;
    wait_idle();
  endtask

  // Command plus pending read: both flags rise together so the launch sees
  // them at the same time and sends one full-duplex frame.
  task automatic duplex(input logic [31:0] d, input logic [31:0] resp);
    slave_word = resp;
    not_full = 1'b0;
    repeat (3) @(negedge clk);
    not_full  = 1'b1;
    not_empty = 1'b1;
    issue(d, 1'b1, resp, 1'b1);
    not_empty = 1'b0;
    wait_idle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] d;
    logic [31:0] r;
    int n;
    bit saw_bad;

    repeat (3) @(negedge clk);
    check_val("rst_cs", 32'(spi_cs), 32'd1);
    check_val("rst_spi_clk", 32'(spi_clk), 32'd0);
    check_val("rst_mosi", 32'(spi_mosi), 32'd0);
    check_val("rst_tx_ready", 32'(tx_ready), 32'd0);
    check_val("rst_rx_valid", 32'(rx_valid), 32'd0);
    check_val("rst_rx_data", rx_data, 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    rst_n    = 1'b1;
    not_full = 1'b1;
    repeat (4) @(negedge clk);

    // Command only
    slave_word = 32'hFFFF_FFFF;
    issue(32'hA5C3_0F12, 1'b0, 32'h0, 1'b1);
    wait_idle();

    // Read-only poll
    poll(32'h1234_5678);

    // Flow control: held command blocked by not_full
    not_full = 1'b0;
    repeat (3) @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 32'h3C5A_9618;
    saw_bad  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_ready !== 1'b0 || spi_cs !== 1'b1) saw_bad = 1'b1;
    end
    check_val("flow_blocked", 32'(saw_bad), 32'd0);
    exp_mosi_q.push_back(32'h3C5A_9618);
    if (LOOPBACK) exp_rx_q.push_back(32'h3C5A_9618);
    not_full = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (spi_cs !== 1'b0 && n < 10);
    check_val("flow_launch_latency", 32'(n), 32'd3);
    tx_valid = 1'b0;
    tx_data  = $urandom();
    wait_idle();

    // Back-to-back commands
    slave_word = $urandom();
    issue($urandom(), 1'b0, 32'h0, 1'b1);
    issue($urandom(), 1'b0, 32'h0, 1'b1);
    wait_idle();

    // Full duplex
    duplex(32'h7E81_C33C, 32'h9ABC_DEF0);

    // Reset mid-frame at bit 17
    abort_frame = 1'b1;
    issue(32'h0F0F_A5A5, 1'b0, 32'h0, 1'b0);
    n = 0;
    while (nclk < 17 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (nclk < 17) fail_evt("bit17_timeout", "frame too short");
    #2 rst_n = 1'b0;
    #1;
    check_val("abort_cs", 32'(spi_cs), 32'd1);
    check_val("abort_spi_clk", 32'(spi_clk), 32'd0);
    check_val("abort_mosi", 32'(spi_mosi), 32'd0);
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_rx_valid", 32'(rx_valid), 32'd0);
    repeat (3) @(negedge clk);
    rst_n       = 1'b1;
    abort_frame = 1'b0;
    repeat (4) @(negedge clk);
    issue(32'h8421_7BDE, 1'b0, 32'h0, 1'b1);
    wait_idle();

    // Loopback self-test pattern (plain command in the default build)
    issue(32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
    wait_idle();

    // Randomised mix
    for (int i = 0; i < 12; i++) begin
      d = $urandom();
      r = $urandom();
      case ($urandom_range(0, 2))
        0: begin
          slave_word = r;
          issue(d, 1'b0, r, 1'b1);
          wait_idle();
        end
        1: duplex(d, r);
        default: poll(r);
      endcase
    end

    repeat (10) @(negedge clk);
    check_val("exp_mosi_drained", 32'(exp_mosi_q.size()), 32'd0);
    check_val("exp_rx_drained", 32'(exp_rx_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
